// File: rtl/hazard_pipe_ctrl.sv
// hazard_pipe_ctrl: E/M/W instruction-word pipeline, stall and bubble
// generation, forwarding selects and the multiply/divide busy window for
// a five-stage MIPS core. Per-stage result codes come back from the
// result-source translator as res_e/res_m/res_w.
module hazard_pipe_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ir_d,
  input  logic [1:0]  tuse_rs,
  input  logic [1:0]  tuse_rt,
  input  logic        md_use_d,
  input  logic        flush,
  input  logic [1:0]  res_e,
  input  logic [1:0]  res_m,
  input  logic [1:0]  res_w,
  output logic [31:0] ir_e,
  output logic [31:0] ir_m,
  output logic [31:0] ir_w,
  output logic        stall,
  output logic        md_busy,
  output logic [1:0]  fwd_rs_d,
  output logic [1:0]  fwd_rt_d,
  output logic [1:0]  fwd_rs_e,
  output logic [1:0]  fwd_rt_e,
  output logic [1:0]  fwd_rt_m
);

  localparam logic [1:0] RES_NW  = 2'b00;
  localparam logic [1:0] RES_ALU = 2'b01;
  localparam logic [1:0] RES_DM  = 2'b10;
  localparam logic [1:0] RES_PC  = 2'b11;

  localparam logic [3:0] MULT_LD = 4'(MULT_CYC);
  localparam logic [3:0] DIV_LD  = 4'(DIV_CYC);

  logic [31:0] ir_e_q, ir_m_q, ir_w_q;
  logic [31:0] ir_e_d, ir_m_d, ir_w_d;
  logic [3:0]  md_cnt_q, md_cnt_d;

  // Register written by an instruction; 0 when it writes nothing.
  function automatic logic [4:0] dest_of(input logic [31:0] ir, input logic [1:0] res);
    if (res == RES_NW)           dest_of = 5'd0;
    else if (ir[31:26] == 6'd0)  dest_of = ir[15:11];
    else if (ir[31:26] == 6'd3)  dest_of = 5'd31;
    else                         dest_of = ir[20:16];
  endfunction

  // mult/multu/div/divu: SPECIAL opcode, funct 24..27.
  function automatic logic is_md_op(input logic [31:0] ir);
    is_md_op = (ir[31:26] == 6'd0) && (ir[5:2] == 4'b0110);
  endfunction

  // Cycles until the result exists, measured with the producer in E.
  function automatic logic [1:0] tnew_e_of(input logic [1:0] res);
    case (res)
      RES_ALU: tnew_e_of = 2'd1;
      RES_DM:  tnew_e_of = 2'd2;
      default: tnew_e_of = 2'd0;
    endcase
  endfunction

  // D-stage source select: E only supplies PC+8, M supplies ALU/PC results.
  function automatic logic [1:0] fwd_d_sel(input logic [4:0] r,
                                           input logic [4:0] de, input logic [1:0] re,
                                           input logic [4:0] dm, input logic [1:0] rm,
                                           input logic [4:0] dw);
    if (r == 5'd0)                                            fwd_d_sel = 2'b00;
    else if (r == de && re == RES_PC)                         fwd_d_sel = 2'b11;
    else if (r == dm && (rm == RES_ALU || rm == RES_PC))      fwd_d_sel = 2'b01;
    else if (r == dw)                                         fwd_d_sel = 2'b10;
    else                                                      fwd_d_sel = 2'b00;
  endfunction

  // E-stage source select.
  function automatic logic [1:0] fwd_e_sel(input logic [4:0] r,
                                           input logic [4:0] dm, input logic [1:0] rm,
                                           input logic [4:0] dw);
    if (r == 5'd0)                                            fwd_e_sel = 2'b00;
    else if (r == dm && (rm == RES_ALU || rm == RES_PC))      fwd_e_sel = 2'b01;
    else if (r == dw)                                         fwd_e_sel = 2'b10;
    else                                                      fwd_e_sel = 2'b00;
  endfunction

  logic [4:0] rs_d, rt_d, dst_e, dst_m, dst_w;
  logic [1:0] tnew_e, tnew_m;
  logic       stall_rs, stall_rt, stall_md;

  assign rs_d   = ir_d[25:21];
  assign rt_d   = ir_d[20:16];
  assign dst_e  = dest_of(ir_e_q, res_e);
  assign dst_m  = dest_of(ir_m_q, res_m);
  assign dst_w  = dest_of(ir_w_q, res_w);
  assign tnew_e = tnew_e_of(res_e);
  assign tnew_m = (res_m == RES_DM) ? 2'd1 : 2'd0;

  // W always has Tnew 0, which can never exceed a tuse, so only E and M can stall.
  assign stall_rs = (rs_d != 5'd0) && (tuse_rs != 2'd3) &&
                    (((rs_d == dst_e) && (tnew_e > tuse_rs)) ||
                     ((rs_d == dst_m) && (tnew_m > tuse_rs)));
  assign stall_rt = (rt_d != 5'd0) && (tuse_rt != 2'd3) &&
                    (((rt_d == dst_e) && (tnew_e > tuse_rt)) ||
                     ((rt_d == dst_m) && (tnew_m > tuse_rt)));
  assign stall_md = md_use_d && (md_busy || is_md_op(ir_e_q));

  assign stall   = stall_rs | stall_rt | stall_md;
  assign md_busy = (md_cnt_q != 4'd0);

  assign fwd_rs_d = fwd_d_sel(rs_d, dst_e, res_e, dst_m, res_m, dst_w);
  assign fwd_rt_d = fwd_d_sel(rt_d, dst_e, res_e, dst_m, res_m, dst_w);
  assign fwd_rs_e = fwd_e_sel(ir_e_q[25:21], dst_m, res_m, dst_w);
  assign fwd_rt_e = fwd_e_sel(ir_e_q[20:16], dst_m, res_m, dst_w);
  assign fwd_rt_m = ((ir_m_q[20:16] != 5'd0) && (ir_m_q[20:16] == dst_w)) ? 2'b10 : 2'b00;

  assign ir_e = ir_e_q;
  assign ir_m = ir_m_q;
  assign ir_w = ir_w_q;

  // Next-state: flush clears every stage; a stall injects a bubble into E.
  always_comb begin
    ir_w_d = ir_m_q;
    ir_m_d = ir_e_q;
    ir_e_d = stall ? 32'd0 : ir_d;
    if (flush) begin
      ir_w_d = 32'd0;
      ir_m_d = 32'd0;
      ir_e_d = 32'd0;
    end
  end

  // Next-state of the MDU window: a mult/div leaving E (re)loads, otherwise count down.
  // Flush does not cancel a running window since the MDU has already started.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (is_md_op(ir_e_q) && !flush)
      md_cnt_d = ir_e_q[1] ? DIV_LD : MULT_LD;
    else if (md_cnt_q != 4'd0)
      md_cnt_d = md_cnt_q - 4'd1;
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_e_q   <= 32'd0;
      ir_m_q   <= 32'd0;
      ir_w_q   <= 32'd0;
      md_cnt_q <= 4'd0;
    end else begin
      ir_e_q   <= ir_e_d;
      ir_m_q   <= ir_m_d;
      ir_w_q   <= ir_w_d;
      md_cnt_q <= md_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_pipe_ctrl.sv
// Directed bench for hazard_pipe_ctrl; expected values are hand-derived.
module tb_hazard_pipe_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ir_d;
  logic [1:0]  tuse_rs, tuse_rt;
  logic        md_use_d, flush;
  logic [1:0]  res_e, res_m, res_w;
  logic [31:0] ir_e, ir_m, ir_w;
  logic        stall, md_busy;
  logic [1:0]  fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m;

  int checks = 0;
  int errors = 0;

  hazard_pipe_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk(clk), .reset(reset), .ir_d(ir_d), .tuse_rs(tuse_rs), .tuse_rt(tuse_rt),
    .md_use_d(md_use_d), .flush(flush), .res_e(res_e), .res_m(res_m), .res_w(res_w),
    .ir_e(ir_e), .ir_m(ir_m), .ir_w(ir_w), .stall(stall), .md_busy(md_busy),
    .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d), .fwd_rs_e(fwd_rs_e),
    .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int fn);
    rtype = {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction

  function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int imm);
    itype = {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge and sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] LW8, ADDU9, ADDU5, SUBU6, OR11, JAL, BEQ, ORI0, ADDU3, SW8, ADDU9B;
  logic [31:0] DIV, MFLO, MULT, MFHI;

  initial begin
    LW8    = itype(8'h23, 2, 8, 0);
    ADDU9  = rtype(8, 1, 9, 8'h21);
    ADDU5  = rtype(1, 2, 5, 8'h21);
    SUBU6  = rtype(7, 5, 6, 8'h23);
    OR11   = rtype(0, 5, 11, 8'h25);
    JAL    = itype(3, 0, 0, 16);
    BEQ    = itype(4, 31, 0, 3);
    ORI0   = itype(8'h0d, 0, 0, 1);
    ADDU3  = rtype(0, 0, 3, 8'h21);
    SW8    = itype(8'h2b, 2, 8, 0);
    ADDU9B = rtype(1, 8, 9, 8'h21);
    DIV    = rtype(2, 3, 0, 8'h1a);
    MFLO   = rtype(0, 0, 4, 8'h12);
    MULT   = rtype(2, 3, 0, 8'h18);
    MFHI   = rtype(0, 0, 4, 8'h10);

    reset = 1'b1; ir_d = '0; tuse_rs = 2'd3; tuse_rt = 2'd3;
    md_use_d = 1'b0; flush = 1'b0; res_e = 2'b00; res_m = 2'b00; res_w = 2'b00;

    // Reset state
    step();
    chk("rst_ir_e", ir_e, 0);
    chk("rst_ir_m", ir_m, 0);
    chk("rst_ir_w", ir_w, 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_md_busy", 32'(md_busy), 0);
    chk("rst_fwd", {22'd0, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m}, 0);
    reset = 1'b0;

    // Load-use
    ir_d = LW8; tuse_rs = 2'd1; tuse_rt = 2'd3;
    step();
    res_e = 2'b10; ir_d = ADDU9; tuse_rs = 2'd1; tuse_rt = 2'd1; #1;
    chk("lu_stall", 32'(stall), 1);
    step();
    chk("lu_bubble_e", ir_e, 0);
    chk("lu_lw_in_m", ir_m, LW8);
    res_e = 2'b00; res_m = 2'b10; #1;
    chk("lu_stall_m", 32'(stall), 0);
    step();
    res_e = 2'b01; res_m = 2'b00; res_w = 2'b10; ir_d = ADDU5; #1;
    chk("lu_ir_e", ir_e, ADDU9);
    chk("lu_fwd_rs_e_w", 32'(fwd_rs_e), 2);
    chk("lu_fwd_rt_e", 32'(fwd_rt_e), 0);

    // ALU forwarding
    step();
    res_e = 2'b01; res_m = 2'b01; res_w = 2'b00; ir_d = SUBU6;
    step();
    res_w = 2'b01; ir_d = OR11; #1;
    chk("alu_fwd_rt_e_m", 32'(fwd_rt_e), 1);
    chk("alu_stall", 32'(stall), 0);
    chk("alu_fwd_rt_d_m", 32'(fwd_rt_d), 1);
    chk("alu_fwd_rs_e", 32'(fwd_rs_e), 0);
    step();
    ir_d = JAL; tuse_rs = 2'd3; tuse_rt = 2'd3; #1;
    chk("alu_fwd_rt_e_w", 32'(fwd_rt_e), 2);
    chk("alu_fwd_rs_e_r0", 32'(fwd_rs_e), 0);
    chk("alu_fwd_rt_m_w", 32'(fwd_rt_m), 2);

    // Branch after jal
    step();
    res_e = 2'b11; ir_d = BEQ; tuse_rs = 2'd0; tuse_rt = 2'd0; #1;
    chk("jal_fwd_rs_d", 32'(fwd_rs_d), 3);
    chk("jal_stall", 32'(stall), 0);
    chk("jal_fwd_rt_d", 32'(fwd_rt_d), 0);

    // $0 destination and no-write producer
    ir_d = ORI0; tuse_rs = 2'd1; tuse_rt = 2'd3;
    step();
    ir_d = '0; tuse_rs = 2'd3;
    step();
    res_e = 2'b00; res_m = 2'b01; res_w = 2'b11;
    ir_d = ADDU3; tuse_rs = 2'd0; tuse_rt = 2'd0; #1;
    chk("r0_fwd_rs_d", 32'(fwd_rs_d), 0);
    chk("r0_fwd_rt_d", 32'(fwd_rt_d), 0);
    chk("r0_stall", 32'(stall), 0);
    ir_d = SW8; tuse_rs = 2'd1; tuse_rt = 2'd2;
    step();
    res_e = 2'b00; res_m = 2'b00; res_w = 2'b01;
    ir_d = ADDU9B; tuse_rs = 2'd0; tuse_rt = 2'd0; #1;
    chk("nw_ir_e", ir_e, SW8);
    chk("nw_stall", 32'(stall), 0);
    chk("nw_fwd_rt_d", 32'(fwd_rt_d), 0);

    // Divide window: stall 1 + 10 cycles
    res_w = 2'b00; ir_d = DIV; md_use_d = 1'b1; #1;
    chk("div_d_stall", 32'(stall), 0);
    step();
    ir_d = MFLO; tuse_rs = 2'd3; tuse_rt = 2'd3; #1;
    chk("div_e_stall", 32'(stall), 1);
    chk("div_e_busy", 32'(md_busy), 0);
    for (int k = 1; k <= 10; k++) begin
      step();
      chk($sformatf("div_busy_%0d", k), 32'(md_busy), 1);
      chk($sformatf("div_stall_%0d", k), 32'(stall), 1);
      chk($sformatf("div_bubble_%0d", k), ir_e, 0);
    end
    step();
    chk("div_busy_end", 32'(md_busy), 0);
    chk("div_stall_end", 32'(stall), 0);
    step();
    chk("div_mflo_e", ir_e, MFLO);

    // Multiply window: 5 busy cycles
    ir_d = MULT; tuse_rs = 2'd0; tuse_rt = 2'd0; #1;
    chk("mult_d_stall", 32'(stall), 0);
    step();
    ir_d = MFHI; tuse_rs = 2'd3; tuse_rt = 2'd3; #1;
    chk("mult_e_stall", 32'(stall), 1);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk($sformatf("mult_busy_%0d", k), 32'(md_busy), 1);
    end
    step();
    chk("mult_busy_end", 32'(md_busy), 0);
    chk("mult_stall_end", 32'(stall), 0);

    // Reset in the middle of a divide window
    ir_d = DIV; tuse_rs = 2'd0; tuse_rt = 2'd0;
    step();
    ir_d = '0; md_use_d = 1'b0; tuse_rs = 2'd3; tuse_rt = 2'd3;
    for (int k = 1; k <= 4; k++) step();
    chk("rst4_busy_before", 32'(md_busy), 1);
    #1 reset = 1'b1;
    #1;
    chk("rst4_busy", 32'(md_busy), 0);
    chk("rst4_ir_e", ir_e, 0);
    reset = 1'b0;

    // Flush together with a load-use stall while a multiply window runs
    ir_d = MULT; md_use_d = 1'b1; tuse_rs = 2'd0; tuse_rt = 2'd0;
    step();
    ir_d = ADDU5; md_use_d = 1'b0; tuse_rs = 2'd1; tuse_rt = 2'd1;
    step();
    res_e = 2'b01; ir_d = LW8; tuse_rs = 2'd1; tuse_rt = 2'd3;
    step();
    chk("fl_pre_ir_w", ir_w, MULT);
    res_e = 2'b10; res_m = 2'b01; ir_d = ADDU9; tuse_rs = 2'd1; tuse_rt = 2'd1;
    flush = 1'b1; #1;
    chk("fl_stall", 32'(stall), 1);
    step();
    flush = 1'b0; res_e = 2'b00; res_m = 2'b00;
    chk("fl_ir_e", ir_e, 0);
    chk("fl_ir_m", ir_m, 0);
    chk("fl_ir_w", ir_w, 0);
    chk("fl_busy_3", 32'(md_busy), 1);
    step();
    chk("fl_busy_2", 32'(md_busy), 1);
    step();
    chk("fl_busy_1", 32'(md_busy), 1);
    step();
    chk("fl_busy_0", 32'(md_busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
